// File: rtl/program_loader_pkg.sv
// ============================================================================
//  Module   : program_loader_pkg
//  Brief    : Shared constants for the instruction-memory program loader and
//             the processor side (state encodings, sizing defaults, opcodes).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

    // Sizing defaults
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int WORD_W_DEF = 16;

    // Loader state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_LO   = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    // Non-ALU opcodes; ALU ops are every opcode with bit 3 clear
    localparam logic [3:0] OP_MVI = 4'b1000;
    localparam logic [3:0] OP_LD  = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1010;

    // True when the opcode nibble names an instruction the processor executes
    function automatic logic opcode_legal(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == OP_MVI) || (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
// ============================================================================
//  Module   : loader_checksum
//  Brief    : 8-bit XOR accumulator with synchronous clear and enable.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_checksum
    import program_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] acc
);

    logic [7:0] r_acc_q;
    logic [7:0] w_acc_d;

    // Clear has priority over accumulation
    always_comb begin
        w_acc_d = r_acc_q;
        if (clr) begin
            w_acc_d = 8'h00;
        end else if (en) begin
            w_acc_d = r_acc_q ^ data;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_q <= 8'h00;
        end else begin
            r_acc_q <= w_acc_d;
        end
    end

    assign acc = r_acc_q;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
//  Module   : program_loader
//  Brief    : Fills the processor's instruction memory from a byte stream:
//             header (word count N), N words high byte first, XOR checksum.
//             Holds the processor in reset until a load completes cleanly.
//  Options  : PROGRAM_LOADER_OPCODE_CHECK_EN - reject words whose opcode
//             nibble is not executable by the processor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        word_count
);

    localparam logic [7:0] c_DEPTH_B = 8'(DEPTH);

    logic [2:0]        r_state_q,     w_state_d;
    logic              r_we_q,        w_we_d;
    logic [ADDR_W-1:0] r_addr_q,      w_addr_d;
    logic [WORD_W-1:0] r_wdata_q,     w_wdata_d;
    logic              r_cpu_reset_q, w_cpu_reset_d;
    logic              r_done_q,      w_done_d;
    logic              r_error_q,     w_error_d;
    logic [3:0]        r_count_q,     w_count_d;
    logic [3:0]        r_n_q,         w_n_d;
    logic [7:0]        r_hi_q,        w_hi_d;

    logic              w_ready;
    logic              w_xfer;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic [7:0]        w_acc;

    assign w_ready = (r_state_q == ST_HDR) || (r_state_q == ST_HI) ||
                     (r_state_q == ST_LO)  || (r_state_q == ST_CSUM);
    assign w_xfer  = in_valid && w_ready;

    loader_checksum u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .data  (in_data),
        .acc   (w_acc)
    );

    // Session state machine: header check, word assembly, checksum verdict
    always_comb begin
        w_state_d     = r_state_q;
        w_we_d        = 1'b0;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_cpu_reset_d = r_cpu_reset_q;
        w_done_d      = r_done_q;
        w_error_d     = r_error_q;
        w_count_d     = r_count_q;
        w_n_d         = r_n_q;
        w_hi_d        = r_hi_q;
        w_acc_clr     = 1'b0;
        w_acc_en      = 1'b0;

        // The index moves on once the write strobe has been presented
        if (r_we_q) begin
            w_addr_d = r_addr_q + ADDR_W'(1);
        end

        case (r_state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_d     = ST_HDR;
                    w_done_d      = 1'b0;
                    w_error_d     = 1'b0;
                    w_count_d     = 4'd0;
                    w_addr_d      = '0;
                    w_cpu_reset_d = 1'b1;
                    w_acc_clr     = 1'b1;
                end
            end
            ST_HDR: begin
                if (w_xfer) begin
                    if ((in_data == 8'h00) || (in_data > c_DEPTH_B)) begin
                        w_state_d = ST_ERR;
                        w_error_d = 1'b1;
                    end else begin
                        w_n_d     = in_data[3:0];
                        w_acc_en  = 1'b1;
                        w_state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (w_xfer) begin
`ifdef PROGRAM_LOADER_OPCODE_CHECK_EN
                    if (!opcode_legal(in_data[7:4])) begin
                        w_state_d = ST_ERR;
                        w_error_d = 1'b1;
                    end else begin
                        w_hi_d    = in_data;
                        w_acc_en  = 1'b1;
                        w_state_d = ST_LO;
                    end
`else
                    w_hi_d    = in_data;
                    w_acc_en  = 1'b1;
                    w_state_d = ST_LO;
`endif
                end
            end
            ST_LO: begin
                if (w_xfer) begin
                    w_we_d    = 1'b1;
                    w_wdata_d = WORD_W'({r_hi_q, in_data});
                    w_count_d = r_count_q + 4'd1;
                    w_acc_en  = 1'b1;
                    w_state_d = ((r_count_q + 4'd1) == r_n_q) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    if (in_data == w_acc) begin
                        w_state_d     = ST_DONE;
                        w_done_d      = 1'b1;
                        w_cpu_reset_d = 1'b0;
                    end else begin
                        w_state_d = ST_ERR;
                        w_error_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_we_q        <= 1'b0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
            r_cpu_reset_q <= 1'b1;
            r_done_q      <= 1'b0;
            r_error_q     <= 1'b0;
            r_count_q     <= 4'd0;
            r_n_q         <= 4'd0;
            r_hi_q        <= 8'h00;
        end else begin
            r_state_q     <= w_state_d;
            r_we_q        <= w_we_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_cpu_reset_q <= w_cpu_reset_d;
            r_done_q      <= w_done_d;
            r_error_q     <= w_error_d;
            r_count_q     <= w_count_d;
            r_n_q         <= w_n_d;
            r_hi_q        <= w_hi_d;
        end
    end

    assign in_ready   = w_ready;
    assign busy       = w_ready;
    assign imem_we    = r_we_q;
    assign imem_addr  = r_addr_q;
    assign imem_wdata = r_wdata_q;
    assign cpu_reset  = r_cpu_reset_q;
    assign done       = r_done_q;
    assign error      = r_error_q;
    assign word_count = r_count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module   : tb_program_loader
//  Brief    : Directed self-checking bench for program_loader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [2:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [2:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Log every instruction-memory write strobe
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Offer one byte, optionally after an idle gap, and wait for its transfer
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        logic [7:0] acc;
        logic [7:0] hi;
        logic [7:0] lo;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Good load: 02 | 80 07 | 82 02 | 05
        clear_log();
        do_start();
        check("good_busy", 32'(busy), 32'd1);
        check("good_ready", 32'(in_ready), 32'd1);
        check("good_cpurst", 32'(cpu_reset), 32'd1);
        send(8'h02, 0); send(8'h80, 0); send(8'h07, 0);
        send(8'h82, 0); send(8'h02, 0); send(8'h05, 0);
        repeat (2) @(negedge clk);
        check("good_nwr", 32'(wr_addr.size()), 32'd2);
        check("good_a0", 32'(wr_addr[0]), 32'd0);
        check("good_d0", 32'(wr_data[0]), 32'h8007);
        check("good_a1", 32'(wr_addr[1]), 32'd1);
        check("good_d1", 32'(wr_data[1]), 32'h8202);
        check("good_wc", 32'(word_count), 32'd2);
        check("good_done", 32'(done), 32'd1);
        check("good_cpurst_low", 32'(cpu_reset), 32'd0);
        check("good_error", 32'(error), 32'd0);
        check("good_busy_low", 32'(busy), 32'd0);

        // Bad checksum: final byte 06
        clear_log();
        do_start();
        check("bcs_done_clr", 32'(done), 32'd0);
        check("bcs_wc_clr", 32'(word_count), 32'd0);
        check("bcs_cpurst_set", 32'(cpu_reset), 32'd1);
        send(8'h02, 0); send(8'h80, 0); send(8'h07, 0);
        send(8'h82, 0); send(8'h02, 0); send(8'h06, 0);
        repeat (2) @(negedge clk);
        check("bcs_nwr", 32'(wr_addr.size()), 32'd2);
        check("bcs_d1", 32'(wr_data[1]), 32'h8202);
        check("bcs_error", 32'(error), 32'd1);
        check("bcs_done", 32'(done), 32'd0);
        check("bcs_cpurst", 32'(cpu_reset), 32'd1);

        // Bad header 00
        clear_log();
        do_start();
        check("bh0_error_clr", 32'(error), 32'd0);
        send(8'h00, 0);
        repeat (2) @(negedge clk);
        check("bh0_error", 32'(error), 32'd1);
        check("bh0_ready", 32'(in_ready), 32'd0);
        check("bh0_nwr", 32'(wr_addr.size()), 32'd0);

        // Bad header 09
        clear_log();
        do_start();
        send(8'h09, 0);
        repeat (2) @(negedge clk);
        check("bh9_error", 32'(error), 32'd1);
        check("bh9_ready", 32'(in_ready), 32'd0);
        check("bh9_nwr", 32'(wr_addr.size()), 32'd0);

        // Stalled good load: 3 idle cycles before every byte
        clear_log();
        do_start();
        send(8'h02, 3); send(8'h80, 3); send(8'h07, 3);
        send(8'h82, 3); send(8'h02, 3); send(8'h05, 3);
        repeat (2) @(negedge clk);
        check("stl_nwr", 32'(wr_addr.size()), 32'd2);
        check("stl_d0", 32'(wr_data[0]), 32'h8007);
        check("stl_d1", 32'(wr_data[1]), 32'h8202);
        check("stl_wc", 32'(word_count), 32'd2);
        check("stl_done", 32'(done), 32'd1);
        check("stl_error", 32'(error), 32'd0);

        // Byte offered while in DONE is not consumed
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("done_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("done_hold", 32'(done), 32'd1);
        check("done_nwr", 32'(wr_addr.size()), 32'd2);

        // Reset mid-session after the first word is written
        clear_log();
        do_start();
        send(8'h02, 0); send(8'h80, 0); send(8'h07, 0);
        repeat (2) @(negedge clk);
        check("mid_nwr", 32'(wr_addr.size()), 32'd1);
        check("mid_wc", 32'(word_count), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        reset = 1'b0;

        // Full 8-word load after the mid-session reset
        clear_log();
        do_start();
        acc = 8'h08;
        send(8'h08, 0);
        for (int i = 0; i < 8; i++) begin
            hi = 8'(i);
            lo = 8'hA0 + 8'(i);
            acc = acc ^ hi ^ lo;
            send(hi, 0);
            send(lo, 0);
        end
        send(acc, 0);
        repeat (2) @(negedge clk);
        check("full_nwr", 32'(wr_addr.size()), 32'd8);
        check("full_a0", 32'(wr_addr[0]), 32'd0);
        check("full_a7", 32'(wr_addr[7]), 32'd7);
        check("full_d7", 32'(wr_data[7]), 32'h07A7);
        check("full_wc", 32'(word_count), 32'd8);
        check("full_done", 32'(done), 32'd1);
        check("full_addr_wrap", 32'(imem_addr), 32'd0);

        // Opcode nibble 0xB
        clear_log();
        do_start();
`ifdef PROGRAM_LOADER_OPCODE_CHECK_EN
        send(8'h01, 0); send(8'hB0, 0);
        repeat (2) @(negedge clk);
        check("op_error", 32'(error), 32'd1);
        check("op_nwr", 32'(wr_addr.size()), 32'd0);
`else
        send(8'h01, 0); send(8'hB0, 0); send(8'h00, 0); send(8'hB1, 0);
        repeat (2) @(negedge clk);
        check("op_nwr", 32'(wr_addr.size()), 32'd1);
        check("op_d0", 32'(wr_data[0]), 32'hB000);
        check("op_done", 32'(done), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
